video_mode_ctrl: RTL and testbench

Frame-synchronous resolution/mode controller for the HDMI output path. It holds the active timing set (sync/back-porch/display/total, H and V) that feeds the video timing driver and the display generator. Mode-change requests are accepted by handshake. Each change is sequenced at frame boundaries: the output is blanked, the driver is restarted with the new timing, and blanking is held until the new timing settles. The pixel clock is not reconfigured; the refresh rate follows the selected totals.

---
 rtl/video_mode_ctrl_pkg.sv | 53 +++++
 rtl/video_mode_ctrl_if.sv | 9 +
 rtl/video_timing_rom.sv | 20 ++
 rtl/video_mode_ctrl.sv | 169 ++++++++++++++++
 tb/tb_video_mode_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_mode_ctrl_pkg.sv
// Shared video timing definitions: mode encodings, per-mode timing sets,
// the mode controller state encoding and a small helper.
package video_timing_pkg;

    typedef enum logic [1:0] {
        MODE_720P = 2'd0,
        MODE_600P = 2'd1,
        MODE_768P = 2'd2,
        MODE_480P = 2'd3
    } mode_e;

    // One complete timing set as driven to the timing driver
    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_back;
        logic [11:0] h_disp;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_back;
        logic [11:0] v_disp;
    } timing_t;

    localparam timing_t TIMING_720P = '{
        h_total: 12'd1650, h_sync: 12'd40,  h_back: 12'd220, h_disp: 12'd1280,
        v_total: 12'd750,  v_sync: 12'd5,   v_back: 12'd20,  v_disp: 12'd720
    };
    localparam timing_t TIMING_600P = '{
        h_total: 12'd1056, h_sync: 12'd128, h_back: 12'd88,  h_disp: 12'd800,
        v_total: 12'd628,  v_sync: 12'd4,   v_back: 12'd23,  v_disp: 12'd600
    };
    localparam timing_t TIMING_768P = '{
        h_total: 12'd1344, h_sync: 12'd136, h_back: 12'd160, h_disp: 12'd1024,
        v_total: 12'd806,  v_sync: 12'd6,   v_back: 12'd29,  v_disp: 12'd768
    };
    localparam timing_t TIMING_480P = '{
        h_total: 12'd800,  h_sync: 12'd96,  h_back: 12'd48,  h_disp: 12'd640,
        v_total: 12'd525,  v_sync: 12'd2,   v_back: 12'd33,  v_disp: 12'd480
    };

    // Mode controller states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_EOF = 3'd1;
    localparam logic [2:0] ST_BLANK    = 3'd2;
    localparam logic [2:0] ST_LOAD     = 3'd3;
    localparam logic [2:0] ST_SETTLE   = 3'd4;

    // States in which a missing vsync is treated as a stuck driver
    function automatic logic wd_armed(input logic [2:0] st);
        return (st == ST_WAIT_EOF) || (st == ST_BLANK) || (st == ST_SETTLE);
    endfunction

endpackage

// File: rtl/video_mode_ctrl_if.sv
// Mode-change request handshake between a requester and the mode controller.
interface video_mode_ctrl_if;
    logic       mode_req_valid;
    logic [1:0] mode_req_sel;
    logic       mode_req_ready;

    modport master (output mode_req_valid, output mode_req_sel, input  mode_req_ready);
    modport slave  (input  mode_req_valid, input  mode_req_sel, output mode_req_ready);
endinterface

// File: rtl/video_timing_rom.sv
// Combinational mode -> timing set lookup; shared with the display config path.
module video_timing_rom
    import video_timing_pkg::*;
(
    input  logic [1:0] mode_sel,
    output timing_t    timing
);

    // Table lookup; every 2-bit code maps to a defined mode
    always_comb begin
        timing = TIMING_720P;
        case (mode_sel)
            MODE_720P: timing = TIMING_720P;
            MODE_600P: timing = TIMING_600P;
            MODE_768P: timing = TIMING_768P;
            MODE_480P: timing = TIMING_480P;
        endcase
    end

endmodule

// File: rtl/video_mode_ctrl.sv
// Frame-synchronous video mode controller. Holds the active timing set and
// sequences mode changes at frame boundaries: blank on the old timing, one
// restart cycle loading the new timing, then blank while the new timing settles.
module video_mode_ctrl
    import video_timing_pkg::*;
#(
    parameter logic [1:0]  DEFAULT_MODE  = 2'd0,
    parameter logic [3:0]  BLANK_FRAMES  = 4'd2,
    parameter logic [3:0]  SETTLE_FRAMES = 4'd2,
    parameter logic [31:0] TIMEOUT_CYC   = 32'd2_000_000,
    parameter logic        VS_POL        = 1'b1
)
(
    input  logic               pixel_clk,
    input  logic               sys_rst,
    video_mode_ctrl_if.slave   req,
    input  logic               video_vs,
    output logic [11:0]        h_sync,
    output logic [11:0]        h_back,
    output logic [11:0]        h_disp,
    output logic [11:0]        h_total,
    output logic [11:0]        v_sync,
    output logic [11:0]        v_back,
    output logic [11:0]        v_disp,
    output logic [11:0]        v_total,
    output logic [1:0]         mode_cur,
    output logic               driver_rst,
    output logic               blank,
    output logic               switch_done,
    output logic               err_timeout,
    output logic [15:0]        frame_cnt
);

    logic [2:0]  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        done_nxt;
    logic [1:0]  pend;
    logic [31:0] wd_cnt;
    logic        vs_act, vs_act_q, vs_edge;
    logic        wd_hit, frm_edge, accept;
    logic [1:0]  rom_sel;
    timing_t     rom_tmg;
    timing_t     tmg_q;

    // Frame edge detect on the configured vsync polarity
    assign vs_act  = (video_vs == VS_POL);
    assign vs_edge = vs_act & ~vs_act_q;

    // Previous vsync level; kept running through reset so no false edge follows it
    always_ff @(posedge pixel_clk) begin
        vs_act_q <= vs_act;
    end

    // A stalled vsync while sequencing is replaced by a synthetic edge
    assign wd_hit   = wd_armed(state) && (wd_cnt >= TIMEOUT_CYC - 32'd1);
    assign frm_edge = vs_edge | wd_hit;

    assign req.mode_req_ready = (state == ST_IDLE);
    assign accept             = req.mode_req_valid & req.mode_req_ready;
    assign blank              = (state != ST_IDLE);

    // During reset the default mode is looked up, otherwise the pending one
    assign rom_sel = sys_rst ? DEFAULT_MODE : pend;

    video_timing_rom u_rom (
        .mode_sel (rom_sel),
        .timing   (rom_tmg)
    );

    // Sequencer next-state: frame counting in BLANK/SETTLE, one-cycle LOAD
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req.mode_req_sel == mode_cur) done_nxt = 1'b1;
                    else                              state_nxt = ST_WAIT_EOF;
                end
            end
            ST_WAIT_EOF: begin
                if (frm_edge) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = 4'd0;
                end
            end
            ST_BLANK: begin
                if (frm_edge) begin
                    if (cnt == BLANK_FRAMES - 4'd1) state_nxt = ST_LOAD;
                    else                            cnt_nxt   = cnt + 4'd1;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = 4'd0;
            end
            ST_SETTLE: begin
                if (frm_edge) begin
                    if (cnt == SETTLE_FRAMES - 4'd1) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Sequencer state, completion pulse and driver restart
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state       <= ST_SETTLE;
            cnt         <= 4'd0;
            switch_done <= 1'b0;
            driver_rst  <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            switch_done <= done_nxt;
            driver_rst  <= (state_nxt == ST_LOAD);
        end
    end

    // Pending mode capture and timing register; timing only moves in LOAD
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            pend     <= DEFAULT_MODE;
            mode_cur <= DEFAULT_MODE;
            tmg_q    <= rom_tmg;
        end else begin
            if (accept && (req.mode_req_sel != mode_cur)) pend <= req.mode_req_sel;
            if (state == ST_LOAD) begin
                mode_cur <= pend;
                tmg_q    <= rom_tmg;
            end
        end
    end

    // Watchdog, sticky timeout flag and free-running frame counter
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            wd_cnt      <= 32'd0;
            err_timeout <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            if ((state == ST_IDLE) || vs_edge || wd_hit) wd_cnt <= 32'd0;
            else                                         wd_cnt <= wd_cnt + 32'd1;
            if (wd_hit)      err_timeout <= 1'b1;
            else if (accept) err_timeout <= 1'b0;
            if (vs_edge) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign h_total = tmg_q.h_total;
    assign h_sync  = tmg_q.h_sync;
    assign h_back  = tmg_q.h_back;
    assign h_disp  = tmg_q.h_disp;
    assign v_total = tmg_q.v_total;
    assign v_sync  = tmg_q.v_sync;
    assign v_back  = tmg_q.v_back;
    assign v_disp  = tmg_q.v_disp;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Bench for video_mode_ctrl: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_video_mode_ctrl;

    localparam int   BLANK_F   = 2;
    localparam int   SETTLE_F  = 2;
    localparam int   TMO       = 5000;
    localparam int   VS_PERIOD = 1000;
    localparam logic VS_POL    = 1'b1;

    localparam int PH_IDLE = 0, PH_WAIT = 1, PH_BLANK = 2, PH_LOAD = 3, PH_SETTLE = 4;

    // {h_total,h_sync,h_back,h_disp,v_total,v_sync,v_back,v_disp} per mode
    int tbl [4][8] = '{
        '{1650,  40, 220, 1280, 750, 5, 20, 720},
        '{1056, 128,  88,  800, 628, 4, 23, 600},
        '{1344, 136, 160, 1024, 806, 6, 29, 768},
        '{ 800,  96,  48,  640, 525, 2, 33, 480}
    };

    logic        pixel_clk;
    logic        sys_rst;
    logic        video_vs;
    logic [11:0] h_sync, h_back, h_disp, h_total, v_sync, v_back, v_disp, v_total;
    logic [1:0]  mode_cur;
    logic        driver_rst, blank, switch_done, err_timeout;
    logic [15:0] frame_cnt;

    video_mode_ctrl_if rif ();

    video_mode_ctrl #(
        .DEFAULT_MODE  (2'd0),
        .BLANK_FRAMES  (4'(BLANK_F)),
        .SETTLE_FRAMES (4'(SETTLE_F)),
        .TIMEOUT_CYC   (32'(TMO)),
        .VS_POL        (VS_POL)
    ) dut (
        .pixel_clk   (pixel_clk),
        .sys_rst     (sys_rst),
        .req         (rif),
        .video_vs    (video_vs),
        .h_sync      (h_sync),
        .h_back      (h_back),
        .h_disp      (h_disp),
        .h_total     (h_total),
        .v_sync      (v_sync),
        .v_back      (v_back),
        .v_disp      (v_disp),
        .v_total     (v_total),
        .mode_cur    (mode_cur),
        .driver_rst  (driver_rst),
        .blank       (blank),
        .switch_done (switch_done),
        .err_timeout (err_timeout),
        .frame_cnt   (frame_cnt)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    // vsync source: short active pulse once per VS_PERIOD while enabled
    logic vs_en;
    int   vcnt;
    initial begin
        video_vs = ~VS_POL;
        vcnt     = 0;
        forever begin
            @(negedge pixel_clk);
            vcnt     = (vcnt == VS_PERIOD - 1) ? 0 : vcnt + 1;
            video_vs = (vs_en && vcnt < 4) ? VS_POL : ~VS_POL;
        end
    end

    // Reference model: frames-remaining countdown per phase
    bit m_on = 1'b0;
    bit m_vsq = 1'b0;
    int m_ph, m_left, m_mode, m_pend, m_wd, m_fcnt;
    bit m_err, m_done, m_drst;

    always @(posedge pixel_clk) begin
        bit act, real_e, tmo, ev;
        act    = (video_vs == VS_POL);
        real_e = act && !m_vsq;
        m_vsq  = act;
        if (sys_rst) begin
            m_on = 1'b1; m_ph = PH_SETTLE; m_left = SETTLE_F; m_mode = 0; m_pend = 0;
            m_wd = 0; m_err = 1'b0; m_fcnt = 0; m_done = 1'b1 ^ 1'b1; m_drst = 1'b1;
        end else if (m_on) begin
            m_done = 1'b0;
            tmo = (m_ph == PH_WAIT || m_ph == PH_BLANK || m_ph == PH_SETTLE) && (m_wd == TMO - 1);
            ev  = real_e || tmo;
            if (real_e) m_fcnt = (m_fcnt + 1) % 65536;
            if (m_ph == PH_IDLE || ev) m_wd = 0; else m_wd++;
            if (tmo) m_err = 1'b1;
            case (m_ph)
                PH_IDLE: if (rif.mode_req_valid) begin
                    m_err = 1'b0;
                    if (int'(rif.mode_req_sel) == m_mode) m_done = 1'b1;
                    else begin m_pend = int'(rif.mode_req_sel); m_ph = PH_WAIT; end
                end
                PH_WAIT: if (ev) begin m_ph = PH_BLANK; m_left = BLANK_F; end
                PH_BLANK: if (ev) begin
                    m_left--;
                    if (m_left == 0) m_ph = PH_LOAD;
                end
                PH_LOAD: begin m_mode = m_pend; m_ph = PH_SETTLE; m_left = SETTLE_F; end
                default: if (ev) begin
                    m_left--;
                    if (m_left == 0) begin m_ph = PH_IDLE; m_done = 1'b1; end
                end
            endcase
            m_drst = (m_ph == PH_LOAD);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge pixel_clk) begin
        if (m_on) begin
            chk("ready",       32'(rif.mode_req_ready), 32'(m_ph == PH_IDLE));
            chk("blank",       32'(blank),              32'(m_ph != PH_IDLE));
            chk("driver_rst",  32'(driver_rst),         32'(m_drst));
            chk("switch_done", 32'(switch_done),        32'(m_done));
            chk("err_timeout", 32'(err_timeout),        32'(m_err));
            chk("frame_cnt",   32'(frame_cnt),          32'(m_fcnt));
            chk("mode_cur",    32'(mode_cur),           32'(m_mode));
            chk("h_total",     32'(h_total),            32'(tbl[m_mode][0]));
            chk("h_sync",      32'(h_sync),             32'(tbl[m_mode][1]));
            chk("h_back",      32'(h_back),             32'(tbl[m_mode][2]));
            chk("h_disp",      32'(h_disp),             32'(tbl[m_mode][3]));
            chk("v_total",     32'(v_total),            32'(tbl[m_mode][4]));
            chk("v_sync",      32'(v_sync),             32'(tbl[m_mode][5]));
            chk("v_back",      32'(v_back),             32'(tbl[m_mode][6]));
            chk("v_disp",      32'(v_disp),             32'(tbl[m_mode][7]));
        end
    end

    int drst_seen;

    // Wait until ready is high (bounded); counts restart cycles seen on the way
    task automatic wait_idle(input int bound, input string nm);
        int n = 0;
        drst_seen = 0;
        while (!rif.mode_req_ready && n < bound) begin
            @(negedge pixel_clk);
            if (driver_rst) drst_seen++;
            n++;
        end
        chk({nm, "_bound"}, 32'(n < bound), 32'd1);
    endtask

    // Present a request and hold it until it is accepted; returns after the accepting edge
    task automatic req(input logic [1:0] s, input int bound, input string nm);
        int n = 0;
        rif.mode_req_valid = 1'b1;
        rif.mode_req_sel   = s;
        while (!rif.mode_req_ready && n < bound) begin
            @(negedge pixel_clk);
            n++;
        end
        @(negedge pixel_clk);
        rif.mode_req_valid = 1'b0;
        chk({nm, "_accept_bound"}, 32'(n < bound), 32'd1);
    endtask

    initial begin
        int f0, n;
        sys_rst            = 1'b1;
        vs_en              = 1'b1;
        rif.mode_req_valid = 1'b0;
        rif.mode_req_sel   = 2'd0;
        repeat (5) @(negedge pixel_clk);

        // Reset state
        chk("rst_driver_rst", 32'(driver_rst), 32'd1);
        chk("rst_blank",      32'(blank),      32'd1);
        chk("rst_h_total",    32'(h_total),    32'd1650);
        chk("rst_v_total",    32'(v_total),    32'd750);
        chk("rst_frame_cnt",  32'(frame_cnt),  32'd0);
        chk("rst_err",        32'(err_timeout),32'd0);
        sys_rst = 1'b0;
        @(negedge pixel_clk);
        chk("rel_driver_rst", 32'(driver_rst), 32'd0);
        chk("startup_blank",  32'(blank),      32'd1);
        wait_idle(5000, "startup");
        chk("startup_done",   32'(switch_done), 32'd1);
        chk("startup_unblank",32'(blank),       32'd0);

        // 720p -> 800x600
        req(2'd1, 100, "sw1");
        chk("sw1_ready_low", 32'(rif.mode_req_ready), 32'd0);
        chk("sw1_blank",     32'(blank),              32'd1);
        wait_idle(8000, "sw1");
        chk("sw1_done",      32'(switch_done), 32'd1);
        chk("sw1_unblank",   32'(blank),       32'd0);
        chk("sw1_drst_cyc",  32'(drst_seen),   32'd1);
        chk("sw1_h_total",   32'(h_total),     32'd1056);
        chk("sw1_v_disp",    32'(v_disp),      32'd600);
        chk("sw1_mode",      32'(mode_cur),    32'd1);

        // Request for the current mode completes immediately without blanking
        f0 = int'(frame_cnt);
        req(2'd1, 100, "same");
        chk("same_done",     32'(switch_done),        32'd1);
        chk("same_blank",    32'(blank),              32'd0);
        chk("same_ready",    32'(rif.mode_req_ready), 32'd1);
        chk("same_h_total",  32'(h_total),            32'd1056);
        repeat (2500) @(negedge pixel_clk);
        chk("same_fcnt_run", 32'(int'(frame_cnt) - f0 >= 2), 32'd1);

        // vsync stops during BLANK: sequence finishes on watchdog edges
        req(2'd0, 100, "tmo");
        repeat (1500) @(negedge pixel_clk);
        chk("tmo_blank",     32'(blank), 32'd1);
        vs_en = 1'b0;
        wait_idle(30000, "tmo");
        chk("tmo_err",       32'(err_timeout), 32'd1);
        chk("tmo_mode",      32'(mode_cur),    32'd0);
        chk("tmo_h_total",   32'(h_total),     32'd1650);
        vs_en = 1'b1;

        // Accepted request clears the flag; a second request held while busy
        req(2'd3, 100, "sw3");
        chk("sw3_err_clr",   32'(err_timeout), 32'd0);
        req(2'd2, 10000, "hold");
        chk("hold_mode_old", 32'(mode_cur), 32'd3);
        chk("hold_h_old",    32'(h_total),  32'd800);
        wait_idle(8000, "hold");
        chk("hold_h_total",  32'(h_total),  32'd1344);
        chk("hold_mode",     32'(mode_cur), 32'd2);

        // Reset in the middle of SETTLE for 640x480
        req(2'd3, 100, "rst3");
        n = 0;
        while (!driver_rst && n < 8000) begin
            @(negedge pixel_clk);
            n++;
        end
        chk("rst3_load_bound", 32'(n < 8000), 32'd1);
        repeat (300) @(negedge pixel_clk);
        chk("rst3_mode",     32'(mode_cur), 32'd3);
        chk("rst3_blank",    32'(blank),    32'd1);
        sys_rst = 1'b1;
        @(negedge pixel_clk);
        chk("rst3_h_total",  32'(h_total),    32'd1650);
        chk("rst3_mode_def", 32'(mode_cur),   32'd0);
        chk("rst3_blank_r",  32'(blank),      32'd1);
        chk("rst3_fcnt",     32'(frame_cnt),  32'd0);
        chk("rst3_drst",     32'(driver_rst), 32'd1);
        repeat (2) @(negedge pixel_clk);
        sys_rst = 1'b0;
        wait_idle(5000, "rst3_startup");
        chk("rst3_done",     32'(switch_done), 32'd1);

        repeat (5) @(negedge pixel_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
